// File: rtl/z80fi_insn_monitor_if.sv
// Core-side observation signals and the z80fi packet produced from them.
// master drives the core strobes/registers; slave is the monitor.
interface z80fi_insn_monitor_if #(
  parameter int unsigned MAX_LEN = 4
);
  localparam int unsigned INSN_W = 8 * MAX_LEN;
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);

  logic              insn_start;
  logic              fetch_valid;
  logic [7:0]        fetch_byte;
  logic              retire;
  logic [7:0]        reg_a;
  logic [7:0]        reg_f;
  logic [7:0]        reg_i;
  logic [7:0]        reg_r;
  logic [15:0]       reg_ip;
  logic              iff1;
  logic              iff2;

  logic              z80fi_valid;
  logic [INSN_W-1:0] z80fi_insn;
  logic [LEN_W-1:0]  z80fi_insn_len;
  logic [7:0]        z80fi_reg_a_in;
  logic [7:0]        z80fi_reg_a_out;
  logic [7:0]        z80fi_reg_f_in;
  logic [7:0]        z80fi_reg_f_out;
  logic [7:0]        z80fi_reg_i_in;
  logic [7:0]        z80fi_reg_i_out;
  logic [7:0]        z80fi_reg_r_in;
  logic [7:0]        z80fi_reg_r_out;
  logic [15:0]       z80fi_reg_ip_in;
  logic [15:0]       z80fi_reg_ip_out;
  logic              z80fi_iff1_in;
  logic              z80fi_iff1_out;
  logic              z80fi_iff2_in;
  logic              z80fi_iff2_out;
  logic              z80fi_error;

  modport master (
    output insn_start, fetch_valid, fetch_byte, retire,
    output reg_a, reg_f, reg_i, reg_r, reg_ip, iff1, iff2,
    input  z80fi_valid, z80fi_insn, z80fi_insn_len,
    input  z80fi_reg_a_in, z80fi_reg_a_out, z80fi_reg_f_in, z80fi_reg_f_out,
    input  z80fi_reg_i_in, z80fi_reg_i_out, z80fi_reg_r_in, z80fi_reg_r_out,
    input  z80fi_reg_ip_in, z80fi_reg_ip_out,
    input  z80fi_iff1_in, z80fi_iff1_out, z80fi_iff2_in, z80fi_iff2_out,
    input  z80fi_error
  );

  modport slave (
    input  insn_start, fetch_valid, fetch_byte, retire,
    input  reg_a, reg_f, reg_i, reg_r, reg_ip, iff1, iff2,
    output z80fi_valid, z80fi_insn, z80fi_insn_len,
    output z80fi_reg_a_in, z80fi_reg_a_out, z80fi_reg_f_in, z80fi_reg_f_out,
    output z80fi_reg_i_in, z80fi_reg_i_out, z80fi_reg_r_in, z80fi_reg_r_out,
    output z80fi_reg_ip_in, z80fi_reg_ip_out,
    output z80fi_iff1_in, z80fi_iff1_out, z80fi_iff2_in, z80fi_iff2_out,
    output z80fi_error
  );
endinterface

// File: rtl/z80fi_insn_monitor.sv
// Assembles one z80fi packet per retired instruction from fetch/retire strobes.
// Collect buffer is separate from the packet registers so packets hold while the next one builds.
module z80fi_insn_monitor #(
  parameter int unsigned MAX_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  z80fi_insn_monitor_if.slave   bus
);
  localparam int unsigned INSN_W = 8 * MAX_LEN;
  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned SNAP_W = 50;

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [INSN_W-1:0]   buf_q, buf_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic                valid_q, valid_d;
  logic [INSN_W-1:0]   insn_q, insn_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [SNAP_W-1:0]   pin_q, pin_d;
  logic [SNAP_W-1:0]   pout_q, pout_d;
  logic                err_q, err_d;

  logic [SNAP_W-1:0]   live_c;
  logic [INSN_W-1:0]   app_buf_c;
  logic [CNT_W-1:0]    app_cnt_c;
  logic                app_ovf_c;

  assign live_c = {bus.reg_a, bus.reg_f, bus.reg_i, bus.reg_r, bus.reg_ip, bus.iff1, bus.iff2};

  // Buffer contents once this cycle's fetch byte (if any) is appended
  always_comb begin
    app_buf_c = buf_q;
    app_cnt_c = cnt_q;
    app_ovf_c = 1'b0;
    if (bus.fetch_valid) begin
      if (cnt_q == CNT_W'(MAX_LEN)) begin
        app_ovf_c = 1'b1;
      end else begin
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
          if (cnt_q == CNT_W'(i)) app_buf_c[8*i +: 8] = bus.fetch_byte;
        end
        app_cnt_c = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    snap_d  = snap_q;
    valid_d = 1'b0;
    insn_d  = insn_q;
    len_d   = len_q;
    pin_d   = pin_q;
    pout_d  = pout_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.retire) err_d = 1'b1;
      end
      S_COLLECT: begin
        if (bus.retire) begin
          valid_d = 1'b1;
          pin_d   = snap_q;
          pout_d  = live_c;
          state_d = S_IDLE;
          // A coincident insn_start owns this cycle's fetch byte
          if (bus.insn_start) begin
            insn_d = buf_q;
            len_d  = cnt_q;
            if (cnt_q == '0) err_d = 1'b1;
          end else begin
            insn_d = app_buf_c;
            len_d  = app_cnt_c;
            if (app_ovf_c || app_cnt_c == '0) err_d = 1'b1;
          end
        end else if (bus.insn_start) begin
          err_d = 1'b1;
        end else begin
          buf_d = app_buf_c;
          cnt_d = app_cnt_c;
          if (app_ovf_c) err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.insn_start) begin
      state_d     = S_COLLECT;
      snap_d      = live_c;
      buf_d       = '0;
      buf_d[7:0]  = bus.fetch_valid ? bus.fetch_byte : 8'h00;
      cnt_d       = bus.fetch_valid ? CNT_W'(1) : CNT_W'(0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      snap_q  <= '0;
      valid_q <= 1'b0;
      insn_q  <= '0;
      len_q   <= '0;
      pin_q   <= '0;
      pout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
      insn_q  <= insn_d;
      len_q   <= len_d;
      pin_q   <= pin_d;
      pout_q  <= pout_d;
      err_q   <= err_d;
    end
  end

  assign bus.z80fi_valid      = valid_q;
  assign bus.z80fi_insn       = insn_q;
  assign bus.z80fi_insn_len   = len_q;
  assign bus.z80fi_error      = err_q;
  assign bus.z80fi_reg_a_in   = pin_q[49:42];
  assign bus.z80fi_reg_f_in   = pin_q[41:34];
  assign bus.z80fi_reg_i_in   = pin_q[33:26];
  assign bus.z80fi_reg_r_in   = pin_q[25:18];
  assign bus.z80fi_reg_ip_in  = pin_q[17:2];
  assign bus.z80fi_iff1_in    = pin_q[1];
  assign bus.z80fi_iff2_in    = pin_q[0];
  assign bus.z80fi_reg_a_out  = pout_q[49:42];
  assign bus.z80fi_reg_f_out  = pout_q[41:34];
  assign bus.z80fi_reg_i_out  = pout_q[33:26];
  assign bus.z80fi_reg_r_out  = pout_q[25:18];
  assign bus.z80fi_reg_ip_out = pout_q[17:2];
  assign bus.z80fi_iff1_out   = pout_q[1];
  assign bus.z80fi_iff2_out   = pout_q[0];
endmodule
